pc_redirect_gen: RTL and testbench



---
 rtl/pc_pkg.sv | 30 +++
 rtl/pc_redirect_arb.sv | 71 +++++++
 rtl/pc_redirect_gen.sv | 113 +++++++++++
 tb/tb_pc_redirect_gen.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the next-PC generator.
package pc_pkg;

  // Source that loaded the fetch PC
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_JMP  = 3'd1,
    SRC_BR   = 3'd2,
    SRC_EXC  = 3'd3,
    SRC_PEND = 3'd4
  } pc_src_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

  // Priority rank of a redirect, higher wins. A buffered entry ranks
  // below every fresh redirect except when it holds an exception.
  function automatic logic [2:0] src_rank(input pc_src_t src, input logic from_pend);
    logic [2:0] r;
    r = 3'd0;
    case (src)
      SRC_EXC: r = from_pend ? 3'd4 : 3'd5;
      SRC_BR:  r = from_pend ? 3'd1 : 3'd3;
      SRC_JMP: r = from_pend ? 3'd1 : 3'd2;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: fixed-priority select between fresh
// redirects, a buffered entry and the sequential PC, with the target
// alignment check folded in.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(DEFAULT_EXC_VEC),
  parameter int               ALIGN   = 2
) (
  input  logic             exc_valid,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             pend_valid,
  input  pc_src_t          pend_src,
  input  logic [WIDTH-1:0] pend_target,
  input  logic [WIDTH-1:0] seq_pc,
  output logic [WIDTH-1:0] sel_target,
  output pc_src_t          sel_src,
  output logic             sel_from_pend,
  output logic             sel_misalign
);

  logic             in_valid;
  pc_src_t          in_src;
  logic [WIDTH-1:0] in_target;
  logic             in_misalign;
  logic             take_pend;

  // Pick the fresh redirect, then decide between it and the buffered entry
  always_comb begin
    in_valid  = 1'b0;
    in_src    = SRC_SEQ;
    in_target = seq_pc;
    if (exc_valid) begin
      in_valid  = 1'b1;
      in_src    = SRC_EXC;
      in_target = EXC_VEC;
    end else if (br_valid) begin
      in_valid  = 1'b1;
      in_src    = SRC_BR;
      in_target = br_target;
    end else if (jmp_valid) begin
      in_valid  = 1'b1;
      in_src    = SRC_JMP;
      in_target = jmp_target;
    end

    in_misalign = (in_src == SRC_BR || in_src == SRC_JMP) && (|in_target[ALIGN-1:0]);
    // Fresh redirect wins ties against the buffered one
    take_pend   = pend_valid &&
                  (!in_valid || (src_rank(pend_src, 1'b1) > src_rank(in_src, 1'b0)));

    sel_target    = in_target;
    sel_src       = in_src;
    sel_from_pend = 1'b0;
    sel_misalign  = 1'b0;
    if (take_pend) begin
      sel_target    = (pend_src == SRC_EXC) ? EXC_VEC : pend_target;
      sel_src       = pend_src;
      sel_from_pend = 1'b1;
    end else if (in_misalign) begin
      sel_target   = EXC_VEC;
      sel_src      = SRC_EXC;
      sel_misalign = 1'b1;
    end
  end

endmodule

// File: rtl/pc_redirect_gen.sv
// Next-PC generator: owns the fetch PC, buffers redirects seen while
// fetch is stalled and replays them on release.
module pc_redirect_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(DEFAULT_EXC_VEC),
  parameter int               INC      = 4,
  parameter int               ALIGN    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_ready,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] pc,
  output logic [2:0]       pc_src,
  output logic             pending,
  output logic             flush_if,
  output logic             misalign
);

  logic [WIDTH-1:0] pc_reg;
  pc_src_t          pc_src_reg;
  logic             pending_reg;
  logic [WIDTH-1:0] pend_target_reg;
  pc_src_t          pend_src_reg;
  logic             misalign_reg;

  logic [WIDTH-1:0] nx_target;
  pc_src_t          nx_src;
  logic             nx_from_pend;
  logic             nx_misalign;
  logic [WIDTH-1:0] mg_target;
  pc_src_t          mg_src;
  logic             mg_from_pend;
  logic             mg_misalign;
  logic             any_redirect;

  assign any_redirect = br_valid | jmp_valid | exc_valid;

  // Candidate for the PC register when fetch accepts
  pc_redirect_arb #(.WIDTH(WIDTH), .EXC_VEC(EXC_VEC), .ALIGN(ALIGN)) u_next_arb (
    .exc_valid    (exc_valid),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .pend_valid   (pending_reg),
    .pend_src     (pend_src_reg),
    .pend_target  (pend_target_reg),
    .seq_pc       (pc_reg + WIDTH'(INC)),
    .sel_target   (nx_target),
    .sel_src      (nx_src),
    .sel_from_pend(nx_from_pend),
    .sel_misalign (nx_misalign)
  );

  // Merged pending entry when fetch is stalled
  pc_redirect_arb #(.WIDTH(WIDTH), .EXC_VEC(EXC_VEC), .ALIGN(ALIGN)) u_merge_arb (
    .exc_valid    (exc_valid),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .pend_valid   (pending_reg),
    .pend_src     (pend_src_reg),
    .pend_target  (pend_target_reg),
    .seq_pc       ('0),
    .sel_target   (mg_target),
    .sel_src      (mg_src),
    .sel_from_pend(mg_from_pend),
    .sel_misalign (mg_misalign)
  );

  // PC, pending buffer and misalign pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      pc_src_reg      <= SRC_SEQ;
      pending_reg     <= 1'b0;
      pend_target_reg <= '0;
      pend_src_reg    <= SRC_SEQ;
      misalign_reg    <= 1'b0;
    end else if (if_ready) begin
      pc_reg       <= nx_target;
      pc_src_reg   <= (nx_from_pend && nx_src != SRC_EXC) ? SRC_PEND : nx_src;
      pending_reg  <= 1'b0;
      misalign_reg <= nx_misalign;
    end else begin
      misalign_reg <= mg_misalign;
      if (any_redirect) begin
        pending_reg <= 1'b1;
        // A surviving buffered entry stays as it is
        if (!mg_from_pend) begin
          pend_target_reg <= mg_target;
          pend_src_reg    <= mg_src;
        end
      end
    end
  end

  assign pc       = pc_reg;
  assign pc_src   = pc_src_reg;
  assign pending  = pending_reg;
  assign misalign = misalign_reg;
  assign flush_if = any_redirect | (pending_reg & if_ready);

endmodule

// File: tb/tb_pc_redirect_gen.sv
// Directed bench for pc_redirect_gen: expected state is queued when each
// step is driven and compared after the following clock edge.
module tb_pc_redirect_gen;

  logic        clk;
  logic        rst_n;
  logic        if_ready;
  logic        br_valid;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        exc_valid;
  logic [31:0] pc;
  logic [2:0]  pc_src;
  logic        pending;
  logic        flush_if;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  src;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BR = 3'd2, EXC = 3'd3, PEND = 3'd4;

  pc_redirect_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_ready  (if_ready),
    .br_valid  (br_valid),
    .br_target (br_target),
    .jmp_valid (jmp_valid),
    .jmp_target(jmp_target),
    .exc_valid (exc_valid),
    .pc        (pc),
    .pc_src    (pc_src),
    .pending   (pending),
    .flush_if  (flush_if),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check flush_if, queue and check the next state
  task automatic step(input string name, input logic rdy,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic e,
                      input logic exp_flush, input logic [31:0] epc,
                      input logic [2:0] esrc, input logic epend, input logic emis);
    exp_t got;
    @(negedge clk);
    if_ready   = rdy;
    br_valid   = b;
    br_target  = bt;
    jmp_valid  = j;
    jmp_target = jt;
    exc_valid  = e;
    #1;
    chk({name, ".flush_if"}, {31'd0, flush_if}, {31'd0, exp_flush});
    sb_q.push_back('{pc: epc, src: esrc, pend: epend, mis: emis});
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({name, ".pc"}, pc, got.pc);
    chk({name, ".pc_src"}, {29'd0, pc_src}, {29'd0, got.src});
    chk({name, ".pending"}, {31'd0, pending}, {31'd0, got.pend});
    chk({name, ".misalign"}, {31'd0, misalign}, {31'd0, got.mis});
    $display("step %s: pc=%h src=%0d pend=%0b mis=%0b", name, pc, pc_src, pending, misalign);
  endtask

  initial begin
    rst_n = 1'b0; if_ready = 1'b0;
    br_valid = 1'b0; br_target = '0;
    jmp_valid = 1'b0; jmp_target = '0; exc_valid = 1'b0;
    #12;
    chk("rst.pc", pc, 32'h3000);
    chk("rst.pc_src", {29'd0, pc_src}, {29'd0, SEQ});
    chk("rst.pending", {31'd0, pending}, 32'd0);
    chk("rst.misalign", {31'd0, misalign}, 32'd0);
    chk("rst.flush_if", {31'd0, flush_if}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // sequential fetch
    step("seq1", 1, 0, 0, 0, 0, 0, 0, 32'h3004, SEQ, 0, 0);
    step("seq2", 1, 0, 0, 0, 0, 0, 0, 32'h3008, SEQ, 0, 0);
    step("seq3", 1, 0, 0, 0, 0, 0, 0, 32'h300C, SEQ, 0, 0);
    // branch beats jump in the same cycle
    step("br_jmp", 1, 1, 32'h3100, 1, 32'h3200, 0, 1, 32'h3100, BR, 0, 0);
    step("seq4", 1, 0, 0, 0, 0, 0, 0, 32'h3104, SEQ, 0, 0);
    // jump buffered during stall, applied on release
    step("stall_jmp", 0, 0, 0, 1, 32'h3200, 0, 1, 32'h3104, SEQ, 1, 0);
    step("stall_a", 0, 0, 0, 0, 0, 0, 0, 32'h3104, SEQ, 1, 0);
    step("stall_b", 0, 0, 0, 0, 0, 0, 0, 32'h3104, SEQ, 1, 0);
    step("release1", 1, 0, 0, 0, 0, 0, 1, 32'h3200, PEND, 0, 0);
    // exception overrides a buffered jump; a later branch cannot displace it
    step("stall_jmp2", 0, 0, 0, 1, 32'h3200, 0, 1, 32'h3200, PEND, 1, 0);
    step("stall_exc", 0, 0, 0, 0, 0, 1, 1, 32'h3200, PEND, 1, 0);
    step("stall_br", 0, 1, 32'h3300, 0, 0, 0, 1, 32'h3200, PEND, 1, 0);
    step("release2", 1, 0, 0, 0, 0, 0, 1, 32'h4180, EXC, 0, 0);
    // misaligned branch becomes an exception, misalign pulses once
    step("mis_br", 1, 1, 32'h3102, 0, 0, 0, 1, 32'h4180, EXC, 0, 1);
    step("after_mis", 1, 0, 0, 0, 0, 0, 0, 32'h4184, SEQ, 0, 0);
    // misaligned jump while stalled: flagged when buffered, replayed as EXC
    step("mis_jmp_buf", 0, 0, 0, 1, 32'h3201, 0, 1, 32'h4184, SEQ, 1, 1);
    step("release3", 1, 0, 0, 0, 0, 0, 1, 32'h4180, EXC, 0, 0);
    // exception beats branch
    step("exc_br", 1, 1, 32'h3400, 0, 0, 1, 1, 32'h4180, EXC, 0, 0);
    // fresh jump replaces a buffered branch
    step("stall_br2", 0, 1, 32'h3400, 0, 0, 0, 1, 32'h4180, EXC, 1, 0);
    step("stall_jmp3", 0, 0, 0, 1, 32'h3500, 0, 1, 32'h4180, EXC, 1, 0);
    step("release4", 1, 0, 0, 0, 0, 0, 1, 32'h3500, PEND, 0, 0);
    // fresh branch on release beats buffered jump
    step("stall_jmp4", 0, 0, 0, 1, 32'h3600, 0, 1, 32'h3500, PEND, 1, 0);
    step("release_br", 1, 1, 32'h3700, 0, 0, 0, 1, 32'h3700, BR, 0, 0);
    // sequential wrap-around
    step("jmp_top", 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, JMP, 0, 0);
    step("wrap", 1, 0, 0, 0, 0, 0, 0, 32'h0000_0000, SEQ, 0, 0);
    // asynchronous reset while a redirect is buffered
    step("stall_jmp5", 0, 0, 0, 1, 32'h3200, 0, 1, 32'h0000_0000, SEQ, 1, 0);
    #2;
    rst_n = 1'b0;
    br_valid = 1'b0; jmp_valid = 1'b0; exc_valid = 1'b0;
    #1;
    chk("async_rst.pc", pc, 32'h3000);
    chk("async_rst.pending", {31'd0, pending}, 32'd0);
    chk("async_rst.pc_src", {29'd0, pc_src}, {29'd0, SEQ});
    chk("async_rst.misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("resume_hold", 0, 0, 0, 0, 0, 0, 0, 32'h3000, SEQ, 0, 0);
    step("resume1", 1, 0, 0, 0, 0, 0, 0, 32'h3004, SEQ, 0, 0);
    step("resume2", 1, 0, 0, 0, 0, 0, 0, 32'h3008, SEQ, 0, 0);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
